migu_alu_issue: RTL
===================

// Module: migu_alu_issue
// PURPOSE
//  Request/response front end for the MigUAlu execute unit: sits between the issue logic (or a bench
//  stimulus engine) and the combinational ALU. Accepts tagged operations over valid/ready, drives
//  registered cmd/in1/in2 into the ALU, captures out/co, and returns tagged results in order over a
//  valid/ready response port with DEPTH-entry buffering. Flags commands outside the ALU command set.
// PARAMETERS
//  WIDTH      64                     operand/result width
//  CMD_WIDTH  MIGU_ALU_CMD_WIDTH     ALU command width
//  NR_CMDS    MIGU_ALU_NR_COMMANDS   number of legal commands; cmd >= NR_CMDS is illegal
//  TAG_WIDTH  4                      request tag width, returned unchanged with the result
//  DEPTH      2                      response buffer entries (>=2)
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   1          request present
//  req_ready  out  1          request accepted when req_valid && req_ready
//  req_cmd    in   CMD_WIDTH  ALU command
//  req_in1    in   WIDTH      operand 1
//  req_in2    in   WIDTH      operand 2
//  req_tag    in   TAG_WIDTH  request tag
//  alu_cmd    out  CMD_WIDTH  registered command to ALU
//  alu_in1    out  WIDTH      registered operand 1 to ALU
//  alu_in2    out  WIDTH      registered operand 2 to ALU
//  alu_out    in   WIDTH      ALU result (combinational from alu_*)
//  alu_co     in   1          ALU carry-out
//  rsp_valid  out  1          response at buffer head
//  rsp_ready  in   1          response consumed when rsp_valid && rsp_ready
//  rsp_out    out  WIDTH      result
//  rsp_co     out  1          carry-out
//  rsp_err    out  1          1 = illegal command; rsp_out=0, rsp_co=0
//  rsp_tag    out  TAG_WIDTH  tag of the request
//  busy       out  1          s1_valid || count!=0
//  done_cnt   out  32         responses consumed since reset, wraps 0xFFFF_FFFF->0
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=0, count=0, pointers=0, alu_*=0, rsp_valid=0,
//    rsp_*=0, busy=0, done_cnt=0; req_ready=1 in the first cycle after release.
//  - Stage S1: on accept at edge N, alu_cmd/in1/in2, tag and err=(req_cmd>=NR_CMDS) register;
//    s1_valid=1. alu_* hold last value when S1 is empty (no toggling on idle).
//  - Capture: at edge N+1, the S1 entry is pushed {alu_out, alu_co, tag, err} into the FIFO; if err,
//    out/co stored as 0. Latency accept->rsp_valid = 2 cycles; throughput 1 op/cycle with rsp_ready=1.
//  - req_ready = (count + s1_valid - (rsp_valid && rsp_ready)) < DEPTH. Combinational path
//    rsp_ready->req_ready is intentional; no path from req_valid to req_ready.
//  - S1 never stalls: req_ready guarantees a free FIFO slot at capture.
//  - FIFO: in order, wr/rd pointers wrap modulo DEPTH; push and pop in the same cycle at full or
//    empty both legal, count unchanged. Pop when empty impossible (rsp_valid=0).
//  - rsp_* driven from FIFO head; stable while rsp_valid && !rsp_ready.
//  - done_cnt increments on each rsp_valid && rsp_ready.
//  - Reset mid-operation discards S1 and all buffered responses; no partial response emitted.
//  - req_* ignored while !req_ready; X on req_* while req_valid=0 must not propagate.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 2 buffered -> rsp_valid=0, busy=0, done_cnt=0, req_ready=1 after release.
//  2 ADD in1=0xFFFF_FFFF_FFFF_FFFF in2=1 tag=3 -> rsp_valid 2 cycles later, out=0, co=1, tag=3, err=0.
//  3 req_cmd=NR_CMDS tag=7 -> rsp_err=1, rsp_out=0, rsp_co=0, rsp_tag=7; ALU result ignored.
//  4 Back-to-back 16 ops, rsp_ready=1 -> req_ready stays 1, tags 0..15 in order, done_cnt=16.
//  5 rsp_ready=0, keep req_valid=1 -> exactly DEPTH+0 buffered then req_ready=0 (S1+FIFO=DEPTH);
//    rsp_* stable; release rsp_ready -> all drain in order, none lost or duplicated.
//  6 Full FIFO, rsp_ready=1 and req_valid=1 same cycle -> pop and accept together, count constant.

Source files
------------

// File: rtl/migu_alu_issue.sv
// migu_alu_issue: request/response front end for the MigUAlu execute unit.
//   Accepts tagged ALU operations over valid/ready, registers cmd/operands into the
//   combinational ALU (stage S1), captures the result one cycle later into a DEPTH-entry
//   in-order response FIFO, and returns {out, co, err, tag} over a valid/ready port.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready/req_*        request channel (cmd, in1, in2, tag)
//   alu_cmd/alu_in1/alu_in2          registered drive into the ALU
//   alu_out/alu_co                   ALU result, combinational from alu_*
//   rsp_valid/rsp_ready/rsp_*        response channel (out, co, err, tag)
//   busy                             work in S1 or buffered responses pending
//   done_cnt                         responses consumed since reset (wrapping)
module migu_alu_issue #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CMD_WIDTH = 4,
  parameter int unsigned NR_CMDS   = 10,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CMD_WIDTH-1:0] req_cmd,
  input  logic [WIDTH-1:0]     req_in1,
  input  logic [WIDTH-1:0]     req_in2,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic [CMD_WIDTH-1:0] alu_cmd,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_co,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_out,
  output logic                 rsp_co,
  output logic                 rsp_err,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic                 busy,
  output logic [31:0]          done_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1) + 1;

  // Stage S1
  logic                 s1_valid_q, s1_valid_d;
  logic [CMD_WIDTH-1:0] alu_cmd_q, alu_cmd_d;
  logic [WIDTH-1:0]     alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0]     alu_in2_q, alu_in2_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic                 s1_err_q, s1_err_d;

  // Response FIFO
  logic [WIDTH-1:0]     fifo_out_q [DEPTH];
  logic [WIDTH-1:0]     fifo_out_d [DEPTH];
  logic                 fifo_co_q  [DEPTH];
  logic                 fifo_co_d  [DEPTH];
  logic                 fifo_err_q [DEPTH];
  logic                 fifo_err_d [DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag_q [DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag_d [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [31:0]          done_cnt_q, done_cnt_d;

  logic            accept, push, pop;
  logic [CntW-1:0] occ_after;

  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = s1_valid_q;

  // Occupancy (S1 + FIFO) once this cycle's pop leaves; S1 always lands in the FIFO next edge,
  // so a new accept is safe only while this stays below DEPTH.
  assign occ_after = count_q + CntW'(s1_valid_q) - CntW'(pop);
  assign req_ready = (occ_after < CntW'(DEPTH));
  assign accept    = req_valid && req_ready;

  always_comb begin
    s1_valid_d = accept;
    alu_cmd_d  = alu_cmd_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    s1_tag_d   = s1_tag_q;
    s1_err_d   = s1_err_q;
    // Hold ALU inputs when idle so X on req_* never reaches the ALU.
    if (accept) begin
      alu_cmd_d = req_cmd;
      alu_in1_d = req_in1;
      alu_in2_d = req_in2;
      s1_tag_d  = req_tag;
      s1_err_d  = (32'(req_cmd) >= NR_CMDS);
    end
  end

  always_comb begin
    fifo_out_d = fifo_out_q;
    fifo_co_d  = fifo_co_q;
    fifo_err_d = fifo_err_q;
    fifo_tag_d = fifo_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    done_cnt_d = done_cnt_q;
    if (push) begin
      fifo_out_d[wr_ptr_q] = s1_err_q ? '0 : alu_out;
      fifo_co_d[wr_ptr_q]  = s1_err_q ? 1'b0 : alu_co;
      fifo_err_d[wr_ptr_q] = s1_err_q;
      fifo_tag_d[wr_ptr_q] = s1_tag_q;
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d   = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      done_cnt_d = done_cnt_q + 32'd1;
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      alu_cmd_q  <= '0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      s1_tag_q   <= '0;
      s1_err_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_out_q[i] <= '0;
        fifo_co_q[i]  <= 1'b0;
        fifo_err_q[i] <= 1'b0;
        fifo_tag_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      alu_cmd_q  <= alu_cmd_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      s1_tag_q   <= s1_tag_d;
      s1_err_q   <= s1_err_d;
      fifo_out_q <= fifo_out_d;
      fifo_co_q  <= fifo_co_d;
      fifo_err_q <= fifo_err_d;
      fifo_tag_q <= fifo_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign alu_cmd  = alu_cmd_q;
  assign alu_in1  = alu_in1_q;
  assign alu_in2  = alu_in2_q;
  assign rsp_out  = fifo_out_q[rd_ptr_q];
  assign rsp_co   = fifo_co_q[rd_ptr_q];
  assign rsp_err  = fifo_err_q[rd_ptr_q];
  assign rsp_tag  = fifo_tag_q[rd_ptr_q];
  assign busy     = s1_valid_q || (count_q != '0);
  assign done_cnt = done_cnt_q;

endmodule
